// File: rtl/alu_pkg.sv
// Shared opcode/func encodings and the internal ALU operation set for rv_alu.
// The RV32I extension set is enabled by defining ALU_FULL_RV32I_EN.
package alu_pkg;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_XOR,
      ALU_SRA,
      ALU_OR,
      ALU_SLL,
      ALU_SRL,
      ALU_SLT,
      ALU_SLTU,
      ALU_PASS2,
      ALU_ILLEGAL
   } alu_op_e;

endpackage

// File: rtl/rv_alu_decode.sv
// Combinational RV32 opcode/func3/func7 decode into an alu_op_e.
// Extra RV32I encodings are decoded only when ALU_FULL_RV32I_EN is defined.
module rv_alu_decode
   import alu_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [2:0] func3_i,
   input  logic [6:0] func7_i,
   output alu_op_e    op_o
);

   always_comb begin
      op_o = ALU_ILLEGAL;
      unique case (opcode_i)
         OPC_LOAD, OPC_STORE: op_o = ALU_ADD;
         OPC_OP_IMM: begin
            // func7 only matters to tell SRAI from SRLI
            unique case (func3_i)
               F3_ADD: op_o = ALU_ADD;
               F3_AND: op_o = ALU_AND;
`ifdef ALU_FULL_RV32I_EN
               F3_SLT:  op_o = ALU_SLT;
               F3_SLTU: op_o = ALU_SLTU;
               F3_XOR:  op_o = ALU_XOR;
               F3_OR:   op_o = ALU_OR;
               F3_SLL:  op_o = ALU_SLL;
               F3_SR:   op_o = (func7_i == F7_ALT) ? ALU_SRA : ALU_SRL;
`endif
               default: op_o = ALU_ILLEGAL;
            endcase
         end
         OPC_OP: begin
            if (func7_i == F7_BASE) begin
               unique case (func3_i)
                  F3_ADD: op_o = ALU_ADD;
                  F3_XOR: op_o = ALU_XOR;
`ifdef ALU_FULL_RV32I_EN
                  F3_SLL:  op_o = ALU_SLL;
                  F3_SLT:  op_o = ALU_SLT;
                  F3_SLTU: op_o = ALU_SLTU;
                  F3_SR:   op_o = ALU_SRL;
                  F3_OR:   op_o = ALU_OR;
                  F3_AND:  op_o = ALU_AND;
`endif
                  default: op_o = ALU_ILLEGAL;
               endcase
            end else if (func7_i == F7_ALT) begin
               unique case (func3_i)
                  F3_ADD:  op_o = ALU_SUB;
                  F3_SR:   op_o = ALU_SRA;
                  default: op_o = ALU_ILLEGAL;
               endcase
            end
         end
`ifdef ALU_FULL_RV32I_EN
         OPC_LUI: op_o = ALU_PASS2;
`endif
         default: op_o = ALU_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/rv_alu.sv
// Single-cycle integer functional unit: decode, execute and register the tagged result.
// Define ALU_FULL_RV32I_EN to accept the remaining RV32I OP/OP-IMM encodings and LUI.
module rv_alu
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned PREG_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic [6:0]        opcode_i,
   input  logic [2:0]        func3_i,
   input  logic [6:0]        func7_i,
   input  logic [DATA_W-1:0] src1_i,
   input  logic [DATA_W-1:0] src2_i,
   input  logic [PREG_W-1:0] dest_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] result_o,
   output logic [PREG_W-1:0] dest_o,
   output logic              illegal_o
);

   alu_op_e           op;
   logic [DATA_W-1:0] result_d;
   logic [4:0]        shamt;

   logic              valid_q;
   logic              illegal_q;
   logic [DATA_W-1:0] result_q;
   logic [PREG_W-1:0] dest_q;

   rv_alu_decode u_decode (
      .opcode_i (opcode_i),
      .func3_i  (func3_i),
      .func7_i  (func7_i),
      .op_o     (op)
   );

   assign shamt = src2_i[4:0];

   always_comb begin
      result_d = '0;
      unique case (op)
         ALU_ADD:   result_d = src1_i + src2_i;
         ALU_SUB:   result_d = src1_i - src2_i;
         ALU_AND:   result_d = src1_i & src2_i;
         ALU_XOR:   result_d = src1_i ^ src2_i;
         ALU_OR:    result_d = src1_i | src2_i;
         ALU_SRA:   result_d = DATA_W'($signed(src1_i) >>> shamt);
         ALU_SRL:   result_d = src1_i >> shamt;
         ALU_SLL:   result_d = src1_i << shamt;
         ALU_SLT:   result_d = DATA_W'($signed(src1_i) < $signed(src2_i));
         ALU_SLTU:  result_d = DATA_W'(src1_i < src2_i);
         ALU_PASS2: result_d = src2_i;
         default:   result_d = '0;
      endcase
   end

   // result/dest only update on an issue so idle cycles keep the last result visible
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         result_q  <= '0;
         dest_q    <= '0;
      end else begin
         valid_q   <= valid_i;
         illegal_q <= valid_i && (op == ALU_ILLEGAL);
         if (valid_i) begin
            result_q <= result_d;
            dest_q   <= dest_i;
         end
      end
   end

   assign valid_o   = valid_q;
   assign illegal_o = illegal_q;
   assign result_o  = result_q;
   assign dest_o    = dest_q;

endmodule

// File: tb/tb_rv_alu.sv
// Table-driven bench for rv_alu: back-to-back issue of directed vectors plus reset/idle sequences.
module tb_rv_alu;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned PREG_W = 6;
`ifdef ALU_FULL_RV32I_EN
   localparam bit FULL = 1'b1;
`else
   localparam bit FULL = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              valid_i;
   logic [6:0]        opcode_i;
   logic [2:0]        func3_i;
   logic [6:0]        func7_i;
   logic [DATA_W-1:0] src1_i;
   logic [DATA_W-1:0] src2_i;
   logic [PREG_W-1:0] dest_i;
   logic              valid_o;
   logic [DATA_W-1:0] result_o;
   logic [PREG_W-1:0] dest_o;
   logic              illegal_o;

   always #5 clk = ~clk;

   rv_alu #(
      .DATA_W (DATA_W),
      .PREG_W (PREG_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .valid_i   (valid_i),
      .opcode_i  (opcode_i),
      .func3_i   (func3_i),
      .func7_i   (func7_i),
      .src1_i    (src1_i),
      .src2_i    (src2_i),
      .dest_i    (dest_i),
      .valid_o   (valid_o),
      .result_o  (result_o),
      .dest_o    (dest_o),
      .illegal_o (illegal_o)
   );

   typedef struct {
      string       name;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] a;
      logic [31:0] b;
      logic [5:0]  dest;
      logic [31:0] exp;
      logic        ill;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;

   task automatic add(input string name, input logic [6:0] opc, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                      input logic [5:0] dest, input logic [31:0] exp, input logic ill);
      vec_t v;
      v.name = name; v.opc = opc; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b;
      v.dest = dest; v.exp = exp; v.ill = ill;
      vecs.push_back(v);
   endtask

   // Encodings only legal in the full build: expect the value there, illegal/0 otherwise.
   task automatic add_full(input string name, input logic [6:0] opc, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] dest, input logic [31:0] exp);
      add(name, opc, f3, f7, a, b, dest, FULL ? exp : 32'h0, !FULL);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      valid_i  = 1'b1;
      opcode_i = v.opc;
      func3_i  = v.f3;
      func7_i  = v.f7;
      src1_i   = v.a;
      src2_i   = v.b;
      dest_i   = v.dest;
   endtask

   initial begin
      rst = 1'b1; valid_i = 1'b0; opcode_i = '0; func3_i = '0; func7_i = '0;
      src1_i = '0; src2_i = '0; dest_i = '0;

      add("addi",        7'b0010011, 3'b000, 7'h00, 32'd5,        32'd7,        6'd12, 32'd12,       1'b0);
      add("sub_neg",     7'b0110011, 3'b000, 7'h20, 32'd3,        32'd5,        6'd1,  32'hFFFFFFFE, 1'b0);
      add("add_wrap",    7'b0110011, 3'b000, 7'h00, 32'hFFFFFFFF, 32'd1,        6'd2,  32'h0,        1'b0);
      add("sra_4",       7'b0110011, 3'b101, 7'h20, 32'h80000000, 32'h24,       6'd3,  32'hF8000000, 1'b0);
      add("sra_31",      7'b0110011, 3'b101, 7'h20, 32'h80000000, 32'd31,       6'd4,  32'hFFFFFFFF, 1'b0);
      add("sra_0",       7'b0110011, 3'b101, 7'h20, 32'h80000001, 32'h20,       6'd5,  32'h80000001, 1'b0);
      add("sra_pos",     7'b0110011, 3'b101, 7'h20, 32'h70000000, 32'd4,        6'd6,  32'h07000000, 1'b0);
      add("xor",         7'b0110011, 3'b100, 7'h00, 32'hF0F0,     32'h0FF0,     6'd7,  32'hFF00,     1'b0);
      add("andi",        7'b0010011, 3'b111, 7'h00, 32'hFF,       32'h0F,       6'd8,  32'h0F,       1'b0);
      add("lw",          7'b0000011, 3'b010, 7'h00, 32'h100,      32'h8,        6'd9,  32'h108,      1'b0);
      add("sw",          7'b0100011, 3'b000, 7'h7F, 32'h1000,     32'hFFFFFFFC, 6'd10, 32'hFFC,      1'b0);
      add("addi_f7",     7'b0010011, 3'b000, 7'h7F, 32'd100,      32'hFFFFFFFF, 6'd11, 32'd99,       1'b0);
      add("branch_ill",  7'b1100011, 3'b000, 7'h00, 32'd1,        32'd1,        6'd13, 32'h0,        1'b1);
      add("add_badf7",   7'b0110011, 3'b000, 7'h01, 32'd1,        32'd1,        6'd14, 32'h0,        1'b1);
      add("xor_badf7",   7'b0110011, 3'b100, 7'h20, 32'd1,        32'd2,        6'd15, 32'h0,        1'b1);
      add_full("or",     7'b0110011, 3'b110, 7'h00, 32'h3,        32'h4,        6'd16, 32'h7);
      add_full("and",    7'b0110011, 3'b111, 7'h00, 32'hF0,       32'h3C,       6'd17, 32'h30);
      add_full("sll",    7'b0110011, 3'b001, 7'h00, 32'h1,        32'h21,       6'd18, 32'h2);
      add_full("slt",    7'b0110011, 3'b010, 7'h00, 32'hFFFFFFFF, 32'h1,        6'd19, 32'h1);
      add_full("sltu",   7'b0110011, 3'b011, 7'h00, 32'hFFFFFFFF, 32'h1,        6'd20, 32'h0);
      add_full("srl",    7'b0110011, 3'b101, 7'h00, 32'h80000000, 32'h4,        6'd21, 32'h08000000);
      add_full("slti",   7'b0010011, 3'b010, 7'h00, 32'h5,        32'hFFFFFFFF, 6'd22, 32'h0);
      add_full("sltiu",  7'b0010011, 3'b011, 7'h00, 32'h5,        32'hFFFFFFFF, 6'd23, 32'h1);
      add_full("xori",   7'b0010011, 3'b100, 7'h00, 32'hFF,       32'h0F,       6'd24, 32'hF0);
      add_full("ori",    7'b0010011, 3'b110, 7'h00, 32'h10,       32'h01,       6'd25, 32'h11);
      add_full("slli",   7'b0010011, 3'b001, 7'h00, 32'h3,        32'h4,        6'd26, 32'h30);
      add_full("srli",   7'b0010011, 3'b101, 7'h00, 32'h80000000, 32'h1,        6'd27, 32'h40000000);
      add_full("srai",   7'b0010011, 3'b101, 7'h20, 32'h80000000, 32'h1,        6'd28, 32'hC0000000);
      add_full("lui",    7'b0110111, 3'b000, 7'h00, 32'h5,        32'h12345000, 6'd29, 32'h12345000);
      add("add_last",    7'b0110011, 3'b000, 7'h00, 32'h1234,     32'h1,        6'd33, 32'h1235,     1'b0);

      // Reset held two cycles
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid",   32'(valid_o),   32'h0);
      check("rst_result",  result_o,       32'h0);
      check("rst_dest",    32'(dest_o),    32'h0);
      check("rst_illegal", 32'(illegal_o), 32'h0);

      // Issue while reset is asserted must be dropped
      drive(vecs[0]);
      @(negedge clk);
      check("rstwin_valid",  32'(valid_o), 32'h0);
      check("rstwin_result", result_o,     32'h0);
      check("rstwin_dest",   32'(dest_o),  32'h0);
      valid_i = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("idle_valid", 32'(valid_o), 32'h0);

      // Back-to-back issue of the whole table, one result per cycle
      drive(vecs[0]);
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         check({vecs[i].name, "_valid"},   32'(valid_o),   32'h1);
         check({vecs[i].name, "_result"},  result_o,       vecs[i].exp);
         check({vecs[i].name, "_dest"},    32'(dest_o),    32'(vecs[i].dest));
         check({vecs[i].name, "_illegal"}, 32'(illegal_o), 32'(vecs[i].ill));
         if (i + 1 < vecs.size()) drive(vecs[i + 1]);
         else valid_i = 1'b0;
      end

      // Idle: valid/illegal drop, result/dest hold the last issue
      @(negedge clk);
      check("hold_valid",  32'(valid_o), 32'h0);
      check("hold_result", result_o,     32'h1235);
      check("hold_dest",   32'(dest_o),  32'd33);

      // Illegal then idle: illegal_o must clear
      drive(vecs[12]);
      @(negedge clk);
      check("ill_seq_illegal", 32'(illegal_o), 32'h1);
      check("ill_seq_result",  result_o,       32'h0);
      valid_i = 1'b0;
      @(negedge clk);
      check("ill_clear",       32'(illegal_o), 32'h0);
      check("ill_clear_valid", 32'(valid_o),   32'h0);

      // Mid-run reset clears everything
      rst = 1'b1;
      @(negedge clk);
      check("rst2_dest",   32'(dest_o), 32'h0);
      check("rst2_result", result_o,    32'h0);
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
